branch_ctrl: RTL and testbench
==============================

// Module: branch_ctrl
// PURPOSE
//  ID-stage branch controller for the pipelined RV32I core. Sequences the
//  comparator (result one-hot: 001 eq, 010 lt, 100 gt): stalls until operands
//  are forwardable and decodes funct3 against the compare result. Drives
//  registered redirect/flush for B-type, JAL and JALR.
// PARAMETERS
//  PC_W   32  width of PC and target buses
//  CNT_W  32  width of statistics counters (BRANCH_STATS_EN only)
// PORTS
//  clk            in   1     core clock, rising edge
//  rst_n          in   1     asynchronous active-low reset
//  id_valid       in   1     valid instruction in ID
//  id_is_branch   in   1     B-type
//  id_is_jal      in   1     JAL
//  id_is_jalr     in   1     JALR (reads rs1 only)
//  id_funct3      in   3     branch condition
//  id_rs1/id_rs2  in   5     source regs
//  ex_rd/mem_rd   in   5     dest regs in EX/MEM
//  ex_regwrite    in   1     EX writes rd
//  ex_memread     in   1     EX is load
//  mem_memread    in   1     MEM is load
//  cmp_result     in   3     comparator one-hot {gt,lt,eq}, signed
//  cmp_ltu        in   1     unsigned rs1<rs2 from datapath
//  br_target      in   PC_W  PC+imm for B-type/JAL
//  jalr_target    in   PC_W  (rs1+imm)&~1
//  id_kill        in   1     older-instr flush; aborts ID instr
//  stall_id       out  1     hold PC and IF/ID (combinational)
//  redirect_valid out  1     1-cycle pulse, registered
//  redirect_pc    out  PC_W  target, valid with redirect_valid
//  flush_if_id    out  1     equals redirect_valid; kills wrong-path fetch
// BEHAVIOUR
//  Reset: state IDLE, wait cnt 0, redirect_valid 0, redirect_pc 0, flush_if_id 0.
//  Operand match: rd!=0 && rd==rs1, or rd==rs2 for B-type only.
//  Hazard depth H: EX load match ->2; else EX ALU (regwrite&!memread) match
//   ->1; else MEM load match ->1; else 0.
//  States IDLE, WAIT, RESOLVE:
//   IDLE: act = id_valid & !id_kill & !redirect_valid & (branch|jal|jalr).
//    act & JAL -> resolve this cycle (no hazard check).
//    act & H==0 -> resolve this cycle, stay IDLE.
//    act & H>0 -> stall_id=1, cnt<=H-1; go WAIT if H==2, else RESOLVE.
//   WAIT: stall_id=1, hazard inputs ignored; next RESOLVE.
//   RESOLVE: stall_id=0, resolve unconditionally (operands forwarded); -> IDLE.
//   id_kill in WAIT/RESOLVE: stall_id=0, no redirect, -> IDLE next cycle.
//  Condition: BEQ eq; BNE !eq; BLT lt; BGE gt|eq; BLTU cmp_ltu;
//   BGEU !cmp_ltu; funct3 010/011 never taken (illegal, no redirect).
//   Non-one-hot cmp_result treated as not taken.
//  Resolve: taken B-type/JAL -> next edge redirect_valid=1,
//   redirect_pc=br_target; JALR -> always, redirect_pc=jalr_target.
//   Not taken -> nothing (fall-through fetch is correct).
//  Latency: redirect 1 cycle after resolve cycle; pulse lasts exactly 1 cycle;
//   redirect_pc holds last value otherwise.
//  While redirect_valid=1 the ID instr is wrong-path: ignored, no stall.
// CONFIGURATION
//  BRANCH_STATS_EN defined: adds outputs stat_branches, stat_taken (CNT_W)
//   counting resolved B-type / taken B-type; reset 0, wrap at 2^CNT_W.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  BEQ, cmp_result=001, no hazard -> next cycle redirect_valid=1, redirect_pc=br_target.
//  BLTU, cmp_result=100, cmp_ltu=1 -> taken; BGE with cmp_result=010 -> no redirect.
//  BNE rs1=x5, EX load rd=x5 -> stall_id 1,1,0; redirect on 4th cycle.
//  JALR rs1=x7, EX ALU rd=x7; rs2=x7 unused? no -> 1 stall; x0 match -> 0 stall.
//  Branch in ID during redirect pulse -> ignored; id_kill during WAIT -> no redirect.
//  Async rst_n low mid-WAIT -> outputs 0 at once, IDLE after release.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// ----------------------------------------------------------------------------
// branch_ctrl_if
//   Bundles the ID-stage branch controller's pipeline-side signals.
//   master : pipeline/driver side (ID decode, hazard info, comparator, targets)
//   slave  : branch_ctrl side (consumes the above, drives stall/redirect/flush)
// Signals:
//   id_valid, id_is_branch, id_is_jal, id_is_jalr, id_funct3, id_rs1, id_rs2
//   ex_rd, mem_rd, ex_regwrite, ex_memread, mem_memread
//   cmp_result {gt,lt,eq} one-hot, cmp_ltu, br_target, jalr_target, id_kill
//   stall_id, redirect_valid, redirect_pc, flush_if_id
// ----------------------------------------------------------------------------
interface branch_ctrl_if #(
    parameter int unsigned PC_W = 32
);
    logic            id_valid;
    logic            id_is_branch;
    logic            id_is_jal;
    logic            id_is_jalr;
    logic [2:0]      id_funct3;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      ex_rd;
    logic [4:0]      mem_rd;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            mem_memread;
    logic [2:0]      cmp_result;
    logic            cmp_ltu;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] jalr_target;
    logic            id_kill;
    logic            stall_id;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            flush_if_id;

    modport master (
        output id_valid, id_is_branch, id_is_jal, id_is_jalr, id_funct3, id_rs1, id_rs2,
        output ex_rd, mem_rd, ex_regwrite, ex_memread, mem_memread,
        output cmp_result, cmp_ltu, br_target, jalr_target, id_kill,
        input  stall_id, redirect_valid, redirect_pc, flush_if_id
    );

    modport slave (
        input  id_valid, id_is_branch, id_is_jal, id_is_jalr, id_funct3, id_rs1, id_rs2,
        input  ex_rd, mem_rd, ex_regwrite, ex_memread, mem_memread,
        input  cmp_result, cmp_ltu, br_target, jalr_target, id_kill,
        output stall_id, redirect_valid, redirect_pc, flush_if_id
    );
endinterface

// File: rtl/branch_ctrl.sv
// ----------------------------------------------------------------------------
// branch_ctrl
//   ID-stage branch controller. Stalls a branch/JALR in ID until its operands
//   can be forwarded, decodes funct3 against the comparator result and issues a
//   registered one-cycle redirect (with matching IF/ID flush) for taken
//   B-type, JAL and JALR.
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   bus (slave)   : ID/hazard/comparator inputs, stall/redirect/flush outputs
//   stat_branches : resolved B-type count      (BRANCH_STATS_EN only)
//   stat_taken    : taken B-type count         (BRANCH_STATS_EN only)
// Configuration:
//   BRANCH_STATS_EN : define to add the statistics counters and ports.
// ----------------------------------------------------------------------------
module branch_ctrl #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_ctrl_if.slave     bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_taken
`endif
);

    typedef enum logic [1:0] {StIdle, StWait, StResolve} state_e;

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;

    logic       ex_match, mem_match;
    logic [1:0] hz;
    logic       act, stall, resolve, cond, taken, cmp_onehot;

    // rs2 only matters for B-type; JALR/JAL never read it.
    always_comb begin
        ex_match  = (bus.ex_rd != 5'd0) &&
                    ((bus.ex_rd == bus.id_rs1) ||
                     (bus.id_is_branch && (bus.ex_rd == bus.id_rs2)));
        mem_match = (bus.mem_rd != 5'd0) &&
                    ((bus.mem_rd == bus.id_rs1) ||
                     (bus.id_is_branch && (bus.mem_rd == bus.id_rs2)));
        hz = 2'd0;
        if (bus.ex_memread && ex_match) begin
            hz = 2'd2;
        end else if (bus.ex_regwrite && !bus.ex_memread && ex_match) begin
            hz = 2'd1;
        end else if (bus.mem_memread && mem_match) begin
            hz = 2'd1;
        end
    end

    // Branch condition; a malformed comparator result never takes a branch.
    always_comb begin
        cmp_onehot = (bus.cmp_result == 3'b001) || (bus.cmp_result == 3'b010) ||
                     (bus.cmp_result == 3'b100);
        cond = 1'b0;
        case (bus.id_funct3)
            3'b000:  cond = bus.cmp_result[0];
            3'b001:  cond = !bus.cmp_result[0];
            3'b100:  cond = bus.cmp_result[1];
            3'b101:  cond = bus.cmp_result[2] | bus.cmp_result[0];
            3'b110:  cond = bus.cmp_ltu;
            3'b111:  cond = !bus.cmp_ltu;
            default: cond = 1'b0;
        endcase
        cond  = cond & cmp_onehot;
        taken = bus.id_is_jal | bus.id_is_jalr | (bus.id_is_branch & cond);
    end

    // An instruction seen during the redirect pulse is on the wrong path.
    assign act = bus.id_valid & ~bus.id_kill & ~redirect_valid_q &
                 (bus.id_is_branch | bus.id_is_jal | bus.id_is_jalr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        resolve = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (act) begin
                    if (bus.id_is_jal || (hz == 2'd0)) begin
                        resolve = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        cnt_d   = hz - 2'd1;
                        state_d = (hz == 2'd2) ? StWait : StResolve;
                    end
                end
            end
            StWait: begin
                if (bus.id_kill) begin
                    cnt_d   = 2'd0;
                    state_d = StIdle;
                end else begin
                    stall   = 1'b1;
                    cnt_d   = cnt_q - 2'd1;
                    state_d = StResolve;
                end
            end
            StResolve: begin
                resolve = ~bus.id_kill;
                cnt_d   = 2'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        redirect_valid_d = resolve & taken;
        redirect_pc_d    = redirect_pc_q;
        if (resolve && taken) begin
            redirect_pc_d = (bus.id_is_jalr && !bus.id_is_jal) ? bus.jalr_target
                                                                : bus.br_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            cnt_q            <= 2'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign bus.stall_id       = stall;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush_if_id    = redirect_valid_q;

`ifdef BRANCH_STATS_EN
    logic             br_resolve;
    logic [CNT_W-1:0] stat_branches_q, stat_taken_q;

    assign br_resolve = resolve & bus.id_is_branch & ~bus.id_is_jal & ~bus.id_is_jalr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_taken_q    <= '0;
        end else begin
            if (br_resolve)         stat_branches_q <= stat_branches_q + 1'b1;
            if (br_resolve && cond) stat_taken_q    <= stat_taken_q + 1'b1;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_taken    = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    branch_ctrl_if #(.PC_W(32)) bus ();

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_taken;
`endif

    branch_ctrl #(.PC_W(32), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_valid     = 1'b0;
        bus.id_is_branch = 1'b0;
        bus.id_is_jal    = 1'b0;
        bus.id_is_jalr   = 1'b0;
        bus.id_funct3    = 3'd0;
        bus.id_rs1       = 5'd0;
        bus.id_rs2       = 5'd0;
        bus.ex_rd        = 5'd0;
        bus.mem_rd       = 5'd0;
        bus.ex_regwrite  = 1'b0;
        bus.ex_memread   = 1'b0;
        bus.mem_memread  = 1'b0;
        bus.cmp_result   = 3'b000;
        bus.cmp_ltu      = 1'b0;
        bus.br_target    = 32'd0;
        bus.jalr_target  = 32'd0;
        bus.id_kill      = 1'b0;
    endtask

    task automatic set_branch(input logic [2:0] f3, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] cmp,
                              input logic ltu, input logic [31:0] tgt);
        bus.id_valid     = 1'b1;
        bus.id_is_branch = 1'b1;
        bus.id_funct3    = f3;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.cmp_result   = cmp;
        bus.cmp_ltu      = ltu;
        bus.br_target    = tgt;
    endtask

    task automatic test_reset();
        checks++; if (bus.stall_id !== 1'b0) begin
            $display("FAIL reset_stall: got %b want 0", bus.stall_id); errors++; end
        checks++; if (bus.redirect_valid !== 1'b0) begin
            $display("FAIL reset_rv: got %b want 0", bus.redirect_valid); errors++; end
        checks++; if (bus.redirect_pc !== 32'd0) begin
            $display("FAIL reset_pc: got %h want 0", bus.redirect_pc); errors++; end
        checks++; if (bus.flush_if_id !== 1'b0) begin
            $display("FAIL reset_flush: got %b want 0", bus.flush_if_id); errors++; end
    endtask

    task automatic test_beq_taken();
        set_branch(3'b000, 5'd1, 5'd2, 3'b001, 1'b0, 32'h0000_0100);
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin
            $display("FAIL beq_stall: got %b want 0", bus.stall_id); errors++; end
        step();
        idle_inputs();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.flush_if_id !== 1'b1) begin
            $display("FAIL beq_rv: got %b/%b want 1/1", bus.redirect_valid, bus.flush_if_id);
            errors++; end
        checks++; if (bus.redirect_pc !== 32'h100) begin
            $display("FAIL beq_pc: got %h want 100", bus.redirect_pc); errors++; end
        step();
        checks++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h100) begin
            $display("FAIL beq_pulse: got %b/%h want 0/100", bus.redirect_valid,
                     bus.redirect_pc); errors++; end
    endtask

    task automatic test_conditions();
        // BLTU with gt but unsigned less -> taken
        set_branch(3'b110, 5'd1, 5'd2, 3'b100, 1'b1, 32'h0000_0200);
        step();
        idle_inputs();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h200) begin
            $display("FAIL bltu: got %b/%h want 1/200", bus.redirect_valid, bus.redirect_pc);
            errors++; end
        step();
        // BGE with lt -> not taken
        set_branch(3'b101, 5'd1, 5'd2, 3'b010, 1'b0, 32'h0000_0240);
        step();
        idle_inputs();
        checks++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h200) begin
            $display("FAIL bge_nt: got %b/%h want 0/200", bus.redirect_valid, bus.redirect_pc);
            errors++; end
        // illegal funct3 010 never taken
        set_branch(3'b010, 5'd1, 5'd2, 3'b001, 1'b1, 32'h0000_0280);
        step();
        idle_inputs();
        checks++; if (bus.redirect_valid !== 1'b0) begin
            $display("FAIL illegal_f3: got %b want 0", bus.redirect_valid); errors++; end
        // BEQ with non-one-hot result not taken
        set_branch(3'b000, 5'd1, 5'd2, 3'b011, 1'b0, 32'h0000_02c0);
        step();
        idle_inputs();
        checks++; if (bus.redirect_valid !== 1'b0) begin
            $display("FAIL nonhot: got %b want 0", bus.redirect_valid); errors++; end
        // BGEU with !ltu -> taken
        set_branch(3'b111, 5'd1, 5'd2, 3'b010, 1'b0, 32'h0000_0220);
        step();
        idle_inputs();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h220) begin
            $display("FAIL bgeu: got %b/%h want 1/220", bus.redirect_valid, bus.redirect_pc);
            errors++; end
        step();
    endtask

    task automatic test_load_hazard();
        logic [2:0] exp_stall;
        exp_stall = 3'b011;  // cycle0,1 stall; cycle2 not
        set_branch(3'b001, 5'd5, 5'd6, 3'b010, 1'b0, 32'h0000_0300);
        bus.ex_rd       = 5'd5;
        bus.ex_memread  = 1'b1;
        bus.ex_regwrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.stall_id !== exp_stall[i] || bus.redirect_valid !== 1'b0) begin
                $display("FAIL load_stall%0d: got %b/%b want %b/0", i, bus.stall_id,
                         bus.redirect_valid, exp_stall[i]); errors++; end
            step();
        end
        idle_inputs();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h300) begin
            $display("FAIL load_rv: got %b/%h want 1/300", bus.redirect_valid, bus.redirect_pc);
            errors++; end
        step();
    endtask

    task automatic test_jalr_hazard();
        bus.id_valid    = 1'b1;
        bus.id_is_jalr  = 1'b1;
        bus.id_rs1      = 5'd7;
        bus.id_rs2      = 5'd7;
        bus.ex_rd       = 5'd7;
        bus.ex_regwrite = 1'b1;
        bus.jalr_target = 32'h0000_0400;
        bus.br_target   = 32'h0000_0bad;
        #1;
        checks++; if (bus.stall_id !== 1'b1) begin
            $display("FAIL jalr_stall0: got %b want 1", bus.stall_id); errors++; end
        step();
        checks++; if (bus.stall_id !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            $display("FAIL jalr_stall1: got %b/%b want 0/0", bus.stall_id, bus.redirect_valid);
            errors++; end
        step();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h400) begin
            $display("FAIL jalr_rv: got %b/%h want 1/400", bus.redirect_valid, bus.redirect_pc);
            errors++; end
        idle_inputs();
        step();
        // rs2 match is irrelevant to JALR
        bus.id_valid    = 1'b1;
        bus.id_is_jalr  = 1'b1;
        bus.id_rs1      = 5'd3;
        bus.id_rs2      = 5'd7;
        bus.ex_rd       = 5'd7;
        bus.ex_regwrite = 1'b1;
        bus.jalr_target = 32'h0000_0404;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin
            $display("FAIL jalr_rs2: got %b want 0", bus.stall_id); errors++; end
        step();
        idle_inputs();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h404) begin
            $display("FAIL jalr_rs2_rv: got %b/%h want 1/404", bus.redirect_valid,
                     bus.redirect_pc); errors++; end
        step();
        // x0 never a hazard
        bus.id_valid    = 1'b1;
        bus.id_is_jalr  = 1'b1;
        bus.ex_memread  = 1'b1;
        bus.ex_regwrite = 1'b1;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin
            $display("FAIL jalr_x0: got %b want 0", bus.stall_id); errors++; end
        step();
        idle_inputs();
        step();
        // MEM load on rs2 of a B-type -> one stall
        set_branch(3'b000, 5'd1, 5'd9, 3'b001, 1'b0, 32'h0000_0480);
        bus.mem_rd      = 5'd9;
        bus.mem_memread = 1'b1;
        #1;
        checks++; if (bus.stall_id !== 1'b1) begin
            $display("FAIL mem_load: got %b want 1", bus.stall_id); errors++; end
        step();
        step();
        idle_inputs();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h480) begin
            $display("FAIL mem_load_rv: got %b/%h want 1/480", bus.redirect_valid,
                     bus.redirect_pc); errors++; end
        step();
    endtask

    task automatic test_back_to_back();
        bus.id_valid  = 1'b1;
        bus.id_is_jal = 1'b1;
        bus.ex_rd     = 5'd4;
        bus.id_rs1    = 5'd4;
        bus.ex_memread = 1'b1;
        bus.br_target = 32'h0000_0500;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin
            $display("FAIL jal_nostall: got %b want 0", bus.stall_id); errors++; end
        step();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h500) begin
            $display("FAIL jal_rv: got %b/%h want 1/500", bus.redirect_valid, bus.redirect_pc);
            errors++; end
        // wrong-path branch with load hazard during the pulse
        idle_inputs();
        set_branch(3'b000, 5'd4, 5'd2, 3'b001, 1'b0, 32'h0000_0540);
        bus.ex_rd      = 5'd4;
        bus.ex_memread = 1'b1;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin
            $display("FAIL wrongpath_stall: got %b want 0", bus.stall_id); errors++; end
        step();
        idle_inputs();
        checks++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h500) begin
            $display("FAIL wrongpath_rv: got %b/%h want 0/500", bus.redirect_valid,
                     bus.redirect_pc); errors++; end
        step();
    endtask

    task automatic test_kill_wait();
        set_branch(3'b000, 5'd5, 5'd6, 3'b001, 1'b0, 32'h0000_0600);
        bus.ex_rd      = 5'd5;
        bus.ex_memread = 1'b1;
        step();
        bus.id_kill = 1'b1;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin
            $display("FAIL kill_stall: got %b want 0", bus.stall_id); errors++; end
        step();
        idle_inputs();
        checks++; if (bus.redirect_valid !== 1'b0) begin
            $display("FAIL kill_rv: got %b want 0", bus.redirect_valid); errors++; end
        step();
        checks++; if (bus.redirect_valid !== 1'b0 || bus.stall_id !== 1'b0) begin
            $display("FAIL kill_idle: got %b/%b want 0/0", bus.redirect_valid, bus.stall_id);
            errors++; end
    endtask

    task automatic test_async_reset();
        set_branch(3'b000, 5'd5, 5'd6, 3'b001, 1'b0, 32'h0000_0700);
        bus.ex_rd      = 5'd5;
        bus.ex_memread = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        checks++; if (bus.stall_id !== 1'b0 || bus.redirect_valid !== 1'b0 ||
                      bus.redirect_pc !== 32'd0 || bus.flush_if_id !== 1'b0) begin
            $display("FAIL async_rst: got %b/%b/%h/%b want 0/0/0/0", bus.stall_id,
                     bus.redirect_valid, bus.redirect_pc, bus.flush_if_id); errors++; end
        step();
        rst_n = 1'b1;
        set_branch(3'b000, 5'd1, 5'd2, 3'b001, 1'b0, 32'h0000_0740);
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin
            $display("FAIL post_rst_stall: got %b want 0", bus.stall_id); errors++; end
        step();
        idle_inputs();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h740) begin
            $display("FAIL post_rst_rv: got %b/%h want 1/740", bus.redirect_valid,
                     bus.redirect_pc); errors++; end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        #12;
        test_reset();
        rst_n = 1'b1;
        step();
        test_beq_taken();
        test_conditions();
        test_load_hazard();
        test_jalr_hazard();
        test_back_to_back();
        test_kill_wait();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
